// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// Stopwatch control: debounced start/stop and lap/clear keys drive a 4-state FSM and count-tick prescaler.
// Latency: key edge to STATE change is 2 (sync) + DEB_CYC (debounce) + 2 (event, FSM) cycles; all outputs registered.
// Backpressure: none; CNT_EN/CNT_CLR are fire-and-forget single-cycle pulses.

module sw_debounce #(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  output logic press
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_d;
  logic [DW-1:0] cnt;

  // Two-flop synchronizer; idles high so a released key reads as released.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Debounced level (1 = pressed) flips only after DEB_CYC consecutive differing cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (~sync2 != deb) begin
      if (cnt == DW'(DEB_CYC - 1)) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered one-cycle pulse on the press edge only; releases are silent.
  always_ff @(posedge CLK) begin
    if (RST) begin
      deb_d <= 1'b0;
      press <= 1'b0;
    end else begin
      deb_d <= deb;
      press <= deb & ~deb_d;
    end
  end

endmodule

module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 500_000,
  parameter int unsigned DEB_CYC  = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_SS_N,
  input  logic       KEY_LAP_N,
  output logic       CNT_EN,
  output logic       CNT_CLR,
  output logic       DISP_HOLD,
  output logic       LED_RUN,
  output logic [1:0] STATE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10,
    S_LAP  = 2'b11
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          ev_ss;
  logic          ev_lap;
  logic [PW-1:0] presc;
  logic          count_ok;
  logic          wrap;
  logic          clr_next;
  logic          hold_next;
  logic          run_next;

  sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ss (
    .CLK   (CLK),
    .RST   (RST),
    .key_n (KEY_SS_N),
    .press (ev_ss)
  );

  sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_lap (
    .CLK   (CLK),
    .RST   (RST),
    .key_n (KEY_LAP_N),
    .press (ev_lap)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode (start/stop beats lap on a tie) plus the qualifiers derived from it.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (ev_ss) next_state = S_RUN;
      S_RUN: begin
        if (ev_ss)       next_state = S_STOP;
        else if (ev_lap) next_state = S_LAP;
      end
      S_LAP: begin
        if (ev_ss)       next_state = S_STOP;
        else if (ev_lap) next_state = S_RUN;
      end
      S_STOP: begin
        if (ev_ss)       next_state = S_RUN;
        else if (ev_lap) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    // Count only across edges that stay within RUN/LAP, so entering or leaving STOP neither
    // advances the prescaler nor emits a tick, and a resume continues from the held value.
    count_ok  = ((state == S_RUN) || (state == S_LAP)) &&
                ((next_state == S_RUN) || (next_state == S_LAP));
    wrap      = (presc == PW'(TICK_DIV - 1));
    clr_next  = (state == S_STOP) && (next_state == S_IDLE);
    hold_next = (next_state == S_LAP) || (next_state == S_STOP);
    run_next  = (next_state == S_RUN) || (next_state == S_LAP);
  end

  // Prescaler: zero whenever heading to IDLE, counts while running, holds otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
    end else if (next_state == S_IDLE) begin
      presc <= '0;
    end else if (count_ok) begin
      presc <= wrap ? '0 : presc + 1'b1;
    end
  end

  // Output registers, timed to line up with the STATE they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT_EN    <= 1'b0;
      CNT_CLR   <= 1'b0;
      DISP_HOLD <= 1'b0;
      LED_RUN   <= 1'b0;
    end else begin
      CNT_EN    <= count_ok & wrap;
      CNT_CLR   <= clr_next;
      DISP_HOLD <= hold_next;
      LED_RUN   <= run_next;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
// Bench for stopwatch_ctrl with TICK_DIV=10, DEB_CYC=4: vector table plus timing sequences.
// Inputs change 1ns after the rising edge and outputs are sampled there.
// No backpressure to model; pulse outputs are also tallied on the falling edge.

module tb_stopwatch_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       KEY_SS_N = 1'b1;
  logic       KEY_LAP_N = 1'b1;
  logic       CNT_EN;
  logic       CNT_CLR;
  logic       DISP_HOLD;
  logic       LED_RUN;
  logic [1:0] STATE;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int bad_en = 0;

  typedef struct {
    logic       ss_n;
    logic       lap_n;
    int         cyc;
    logic [1:0] st;
    logic       hold;
    logic       led;
  } vec_t;

  vec_t tbl[$];

  stopwatch_ctrl #(.TICK_DIV(10), .DEB_CYC(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .KEY_SS_N  (KEY_SS_N),
    .KEY_LAP_N (KEY_LAP_N),
    .CNT_EN    (CNT_EN),
    .CNT_CLR   (CNT_CLR),
    .DISP_HOLD (DISP_HOLD),
    .LED_RUN   (LED_RUN),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  // Pulse tallies and the "no tick while stopped/idle" watch.
  always @(negedge CLK) begin
    if (CNT_EN) en_cnt <= en_cnt + 1;
    if (CNT_CLR) clr_cnt <= clr_cnt + 1;
    if (CNT_EN && (STATE == 2'b00 || STATE == 2'b10)) bad_en <= bad_en + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic ss_n, input logic lap_n, input int cyc,
                     input logic [1:0] st, input logic hold, input logic led);
    vec_t v;
    v.ss_n = ss_n; v.lap_n = lap_n; v.cyc = cyc;
    v.st = st; v.hold = hold; v.led = led;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    KEY_SS_N = 1'b1;
    KEY_LAP_N = 1'b1;
    repeat (3) step();
    RST = 1'b0;
  endtask

  // sel: 0 = start/stop, 1 = lap, 2 = both together. Held low for the full 8-cycle latency.
  task automatic press(input int sel);
    if (sel != 1) KEY_SS_N = 1'b0;
    if (sel != 0) KEY_LAP_N = 1'b0;
    repeat (8) step();
    KEY_SS_N = 1'b1;
    KEY_LAP_N = 1'b1;
  endtask

  task automatic wait_en();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (CNT_EN) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_cnt_en", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int clr0;
    int en0;

    // Reset values.
    repeat (3) step();
    chk("rst_state", {30'd0, STATE}, 32'd0);
    chk("rst_cnt_en", {31'd0, CNT_EN}, 32'd0);
    chk("rst_cnt_clr", {31'd0, CNT_CLR}, 32'd0);
    chk("rst_disp_hold", {31'd0, DISP_HOLD}, 32'd0);
    chk("rst_led_run", {31'd0, LED_RUN}, 32'd0);
    RST = 1'b0;

    // ss_n, lap_n, cycles held, expected STATE, DISP_HOLD, LED_RUN
    add(1, 1, 3, 2'b00, 0, 0);
    add(0, 1, 3, 2'b00, 0, 0);   // 3-cycle glitch
    add(1, 1, 8, 2'b00, 0, 0);   // glitch produced nothing
    add(1, 0, 8, 2'b00, 0, 0);   // lap ignored in IDLE
    add(1, 1, 8, 2'b00, 0, 0);
    add(0, 1, 8, 2'b01, 0, 1);   // IDLE -> RUN
    add(1, 1, 8, 2'b01, 0, 1);   // release: no event
    add(1, 0, 8, 2'b11, 1, 1);   // RUN -> LAP
    add(1, 1, 8, 2'b11, 1, 1);
    add(1, 0, 8, 2'b01, 0, 1);   // LAP -> RUN
    add(1, 1, 8, 2'b01, 0, 1);
    add(0, 1, 8, 2'b10, 1, 0);   // RUN -> STOP
    add(1, 1, 8, 2'b10, 1, 0);
    add(0, 1, 8, 2'b01, 0, 1);   // STOP -> RUN
    add(1, 1, 8, 2'b01, 0, 1);
    add(1, 0, 8, 2'b11, 1, 1);   // RUN -> LAP
    add(1, 1, 8, 2'b11, 1, 1);
    add(0, 1, 8, 2'b10, 1, 0);   // LAP -> STOP
    add(1, 1, 8, 2'b10, 1, 0);
    add(1, 0, 8, 2'b00, 0, 0);   // STOP -> IDLE
    add(1, 1, 8, 2'b00, 0, 0);
    add(0, 0, 8, 2'b01, 0, 1);   // both in IDLE -> RUN
    add(1, 1, 8, 2'b01, 0, 1);
    add(0, 0, 8, 2'b10, 1, 0);   // both in RUN: start/stop wins -> STOP
    add(1, 1, 8, 2'b10, 1, 0);
    add(0, 0, 8, 2'b01, 0, 1);   // both in STOP: start/stop wins -> RUN
    add(1, 1, 8, 2'b01, 0, 1);

    clr0 = clr_cnt;
    for (int i = 0; i < tbl.size(); i++) begin
      KEY_SS_N = tbl[i].ss_n;
      KEY_LAP_N = tbl[i].lap_n;
      repeat (tbl[i].cyc) step();
      chk($sformatf("vec%0d_state", i), {30'd0, STATE}, {30'd0, tbl[i].st});
      chk($sformatf("vec%0d_hold", i), {31'd0, DISP_HOLD}, {31'd0, tbl[i].hold});
      chk($sformatf("vec%0d_led", i), {31'd0, LED_RUN}, {31'd0, tbl[i].led});
    end
    chk("vec_clr_pulses", clr_cnt - clr0, 32'd1);

    // Exact press latency and tick period.
    do_reset();
    KEY_SS_N = 1'b0;
    repeat (7) step();
    chk("lat_7_still_idle", {30'd0, STATE}, 32'd0);
    step();
    chk("lat_8_run", {30'd0, STATE}, 32'd1);
    KEY_SS_N = 1'b1;
    repeat (9) step();
    chk("first_en_early", {31'd0, CNT_EN}, 32'd0);
    step();
    chk("first_en", {31'd0, CNT_EN}, 32'd1);
    chk("led_run", {31'd0, LED_RUN}, 32'd1);
    repeat (9) step();
    chk("period_early", {31'd0, CNT_EN}, 32'd0);
    step();
    chk("period_en", {31'd0, CNT_EN}, 32'd1);

    // Lap keeps the tick period.
    KEY_LAP_N = 1'b0;
    repeat (8) step();
    chk("lap_state", {30'd0, STATE}, 32'd3);
    chk("lap_hold", {31'd0, DISP_HOLD}, 32'd1);
    KEY_LAP_N = 1'b1;
    step();
    chk("lap_period_early", {31'd0, CNT_EN}, 32'd0);
    step();
    chk("lap_period_en", {31'd0, CNT_EN}, 32'd1);
    repeat (12) step();
    press(1);
    chk("lap_back_state", {30'd0, STATE}, 32'd1);
    chk("lap_back_hold", {31'd0, DISP_HOLD}, 32'd0);
    repeat (10) step();

    // Stop with prescaler held at 6, resume ticks 4 cycles later.
    wait_en();
    repeat (9) step();
    KEY_SS_N = 1'b0;
    repeat (8) step();
    chk("stop_state", {30'd0, STATE}, 32'd2);
    KEY_SS_N = 1'b1;
    en0 = en_cnt;
    repeat (20) step();
    chk("stop_no_en", en_cnt - en0, 32'd0);
    KEY_SS_N = 1'b0;
    repeat (8) step();
    chk("resume_state", {30'd0, STATE}, 32'd1);
    KEY_SS_N = 1'b1;
    repeat (3) step();
    chk("resume_en_early", {31'd0, CNT_EN}, 32'd0);
    step();
    chk("resume_en_4", {31'd0, CNT_EN}, 32'd1);
    repeat (8) step();

    // STOP -> IDLE gives exactly one clear pulse.
    press(0);
    chk("to_stop", {30'd0, STATE}, 32'd2);
    repeat (8) step();
    clr0 = clr_cnt;
    KEY_LAP_N = 1'b0;
    repeat (8) step();
    chk("clr_state_idle", {30'd0, STATE}, 32'd0);
    chk("clr_pulse", {31'd0, CNT_CLR}, 32'd1);
    step();
    chk("clr_pulse_end", {31'd0, CNT_CLR}, 32'd0);
    KEY_LAP_N = 1'b1;
    repeat (10) step();
    chk("clr_single", clr_cnt - clr0, 32'd1);

    // Reset mid-RUN aborts without a clear pulse.
    press(0);
    chk("pre_rst_run", {30'd0, STATE}, 32'd1);
    repeat (5) step();
    clr0 = clr_cnt;
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_rst_state", {30'd0, STATE}, 32'd0);
    chk("mid_rst_en", {31'd0, CNT_EN}, 32'd0);
    chk("mid_rst_clr", {31'd0, CNT_CLR}, 32'd0);
    chk("mid_rst_hold", {31'd0, DISP_HOLD}, 32'd0);
    chk("mid_rst_led", {31'd0, LED_RUN}, 32'd0);
    repeat (10) step();
    chk("mid_rst_no_clr", clr_cnt - clr0, 32'd0);
    chk("mid_rst_stays_idle", {30'd0, STATE}, 32'd0);

    // Key held through reset release needs the full debounce time.
    KEY_SS_N = 1'b0;
    RST = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    repeat (7) step();
    chk("held_rst_7_idle", {30'd0, STATE}, 32'd0);
    step();
    chk("held_rst_8_run", {30'd0, STATE}, 32'd1);
    KEY_SS_N = 1'b1;
    repeat (10) step();

    chk("no_en_in_idle_stop", bad_en, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500_000, CLK cycles per count tick (100 Hz at 50 MHz).
REQ-002 SHALL have parameter DEB_CYC, default 1_000_000, consecutive stable cycles required to accept a button change (20 ms).
REQ-003 SHALL have port CLK  input  1  system clock, 50 MHz.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port KEY_SS_N  input  1  start/stop button, active-low, asynchronous to CLK.
REQ-006 SHALL have port KEY_LAP_N  input  1  lap/clear button, active-low, asynchronous to CLK.
REQ-007 SHALL have port CNT_EN  output  1  one-cycle count-advance pulse to the time counter.
REQ-008 SHALL have port CNT_CLR  output  1  one-cycle counter clear pulse.
REQ-009 SHALL have port DISP_HOLD  output  1  level; display latch frozen while 1.
REQ-010 SHALL have port LED_RUN  output  1  level; 1 while counting (RUN or LAP).
REQ-011 SHALL have port STATE  output  2  current state: IDLE=00, RUN=01, STOP=10, LAP=11.

Function
REQ-012 Each KEY input SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each debouncer SHALL hold a debounced level, inverted so 1 means pressed, and a counter; the counter increments while the synchronized level differs from the debounced level and clears to 0 when they match.
REQ-014 The debounced level SHALL toggle, and its counter clear, on the cycle the counter reaches DEB_CYC-1; a glitch shorter than DEB_CYC cycles SHALL produce no change.
REQ-015 A press event (EV_SS / EV_LAP) SHALL be a registered one-cycle pulse on a 0->1 debounced transition; releases SHALL produce no event.
REQ-016 The FSM SHALL update on the clock edge following an event cycle; transitions:
 - IDLE: EV_SS -> RUN; EV_LAP ignored.
 - RUN: EV_SS -> STOP; EV_LAP -> LAP.
 - LAP: EV_LAP -> RUN; EV_SS -> STOP.
 - STOP: EV_SS -> RUN; EV_LAP -> IDLE.
REQ-017 EV_SS and EV_LAP in the same cycle: EV_SS SHALL win and EV_LAP SHALL be discarded.
REQ-018 The prescaler, 0..TICK_DIV-1 with width ceil(log2(TICK_DIV)), SHALL count only in RUN and LAP, hold its value in STOP, and be 0 in IDLE.
REQ-019 CNT_EN SHALL be 1 for exactly the cycle after the prescaler equals TICK_DIV-1, with the prescaler wrapping to 0; CNT_EN SHALL never assert in IDLE or STOP.
REQ-020 A STOP->RUN resume SHALL continue from the held prescaler value, so the first CNT_EN after resume arrives TICK_DIV minus the held count cycles later.
REQ-021 CNT_CLR SHALL pulse for one cycle, registered, in the cycle after the STOP->IDLE transition; in that cycle the prescaler SHALL be 0.
REQ-022 DISP_HOLD SHALL be 1 in LAP and STOP and 0 in IDLE and RUN, registered from the state.
REQ-023 LED_RUN SHALL be 1 in RUN and LAP, registered from the state.
REQ-024 All outputs SHALL be registered; no output SHALL be a combinational function of KEY inputs.

Reset
REQ-025 On RST=1 at a CLK edge: state IDLE; prescaler 0; debounce counters 0; debounced levels 0 (released); synchronizers 1.
REQ-026 Reset output values: STATE=00, CNT_EN=0, CNT_CLR=0, DISP_HOLD=0, LED_RUN=0; RST takes priority over all events.
REQ-027 A button held through reset release SHALL produce an event only after DEB_CYC stable cycles; reset mid-RUN SHALL abort to IDLE without a CNT_CLR pulse.

Verification (TICK_DIV=10, DEB_CYC=4)
REQ-028 Bench: KEY_SS_N low for 3 cycles, then high -> no event, STATE stays 00.
REQ-029 Bench: KEY_SS_N held low -> STATE=01 exactly 2+4+2 cycles after the fall; CNT_EN pulses every 10 cycles; LED_RUN=1.
REQ-030 Bench: in RUN, press LAP -> STATE=11, DISP_HOLD=1, CNT_EN keeps its 10-cycle period; press LAP again -> STATE=01, DISP_HOLD=0.
REQ-031 Bench: in RUN with prescaler=6, press SS -> STATE=10, no CNT_EN; press SS again -> first CNT_EN 4 cycles after re-entering RUN.
REQ-032 Bench: in STOP, press LAP -> STATE=00 and a single CNT_CLR pulse; SS and LAP pressed in the same cycle in RUN -> STATE=10.
REQ-033 Bench: assert RST for 1 cycle mid-RUN -> STATE=00, all outputs 0, no CNT_CLR pulse.
